// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: a tick prescaler plus an IDLE/RUN/PAUSE/DONE sequencer
// that steps a down-counter once per tick and flags expiry for the display.
module countdown_timer_ctrl #(
  parameter int unsigned CLK_IN_HZ = 50000000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               load,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic [1:0]         state,
  output logic               tick,
  output logic               done,
  output logic               expired
);

  localparam int unsigned DIV      = CLK_IN_HZ / TICK_HZ;
  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] reload_q, reload_d;
  logic [31:0]        presc_q, presc_d;
  logic               done_q, done_d;
  logic               presc_last;

  // clear and pause both pre-empt a tick landing in the same cycle
  assign presc_last = (presc_q == DIV_LAST);
  assign tick       = (state_q == RUN) && presc_last && !pause && !clear;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          if (load) begin
            reload_d = load_val;
            count_d  = load_val;
          end else if (start && (count_q != '0)) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (presc_last) begin
            presc_d = '0;
            if (count_q != '0) begin
              count_d = count_q - COUNT_W'(1);
            end
            if (count_q == COUNT_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end

        // prescaler keeps its partial count so resuming does not restart the tick
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end

        DONE: begin
          count_d = '0;
          presc_d = '0;
          if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            state_d  = IDLE;
          end else if (start && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign done    = done_q;
  assign expired = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl with DIV=10 (100 Hz clock, 10 Hz tick).
module tb_countdown_timer_ctrl;

  logic        clk_in;
  logic        rst;
  logic [15:0] load_val;
  logic        load;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] count;
  logic [1:0]  state;
  logic        tick;
  logic        done;
  logic        expired;

  int checks;
  int failures;

  countdown_timer_ctrl #(
    .CLK_IN_HZ(100),
    .TICK_HZ  (10),
    .COUNT_W  (16)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .load_val(load_val),
    .load    (load),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .count   (count),
    .state   (state),
    .tick    (tick),
    .done    (done),
    .expired (expired)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // One-cycle strobe set, sampled by the next rising edge
  task automatic applyStimulus(input logic ld, input logic st, input logic pa, input logic cl,
                               input logic [15:0] lv);
    load_val = lv;
    load     = ld;
    start    = st;
    pause    = pa;
    clear    = cl;
    step(1);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    load_val = '0;
    load     = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;

    #2 rst = 1'b1;
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_expired", 32'(expired), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Basic countdown from 3
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    checkOutput("t1_load_state", 32'(state), 32'd0);
    checkOutput("t1_load_count", 32'(count), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    checkOutput("t1_run_state", 32'(state), 32'd1);
    checkOutput("t1_run_tick", 32'(tick), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(8);
      checkOutput("t1_pre_tick", 32'(tick), 32'd0);
      step(1);
      checkOutput("t1_tick", 32'(tick), 32'd1);
      checkOutput("t1_tick_count", 32'(count), 32'(3 - k));
      step(1);
      checkOutput("t1_dec_count", 32'(count), 32'(2 - k));
    end
    checkOutput("t1_done_pulse", 32'(done), 32'd1);
    checkOutput("t1_done_state", 32'(state), 32'd3);
    checkOutput("t1_expired", 32'(expired), 32'd1);
    step(1);
    checkOutput("t1_done_low", 32'(done), 32'd0);
    checkOutput("t1_expired_hold", 32'(expired), 32'd1);
    checkOutput("t1_state_hold", 32'(state), 32'd3);

    // Restart from DONE using reload; load during RUN is ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    checkOutput("t4_restart_state", 32'(state), 32'd1);
    checkOutput("t4_restart_count", 32'(count), 32'd3);
    checkOutput("t4_expired_low", 32'(expired), 32'd0);
    step(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd9);
    checkOutput("t4_load_ign_count", 32'(count), 32'd3);
    checkOutput("t4_load_ign_state", 32'(state), 32'd1);
    step(4);
    checkOutput("t4_tick", 32'(tick), 32'd1);
    step(1);
    checkOutput("t4_count2", 32'(count), 32'd2);
    step(10);
    checkOutput("t4_count1", 32'(count), 32'd1);
    step(10);
    checkOutput("t4_count0", 32'(count), 32'd0);
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_state", 32'(state), 32'd3);

    // Pause mid-tick, hold, resume with the partial tick preserved
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    checkOutput("t2_load_state", 32'(state), 32'd0);
    checkOutput("t2_load_count", 32'(count), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
    step(13);
    checkOutput("t2_count4", 32'(count), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    checkOutput("t2_pause_state", 32'(state), 32'd2);
    step(25);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    checkOutput("t2_pause_again", 32'(state), 32'd2);
    step(24);
    checkOutput("t2_hold_count", 32'(count), 32'd4);
    checkOutput("t2_hold_tick", 32'(tick), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
    checkOutput("t2_resume_state", 32'(state), 32'd1);
    step(5);
    checkOutput("t2_resume_pre_tick", 32'(tick), 32'd0);
    step(1);
    checkOutput("t2_resume_tick", 32'(tick), 32'd1);
    checkOutput("t2_resume_tick_count", 32'(count), 32'd4);
    step(1);
    checkOutput("t2_resume_count3", 32'(count), 32'd3);

    // Pause coincident with a tick suppresses the decrement
    step(9);
    checkOutput("t3_tick_visible", 32'(tick), 32'd1);
    pause = 1'b1;
    #1;
    checkOutput("t3_tick_suppressed", 32'(tick), 32'd0);
    @(posedge clk_in);
    #1;
    pause = 1'b0;
    checkOutput("t3_state_pause", 32'(state), 32'd2);
    checkOutput("t3_count_kept", 32'(count), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    checkOutput("t3_resume_tick", 32'(tick), 32'd1);
    step(1);
    checkOutput("t3_resume_count", 32'(count), 32'd2);

    // Clear beats load in RUN; start with count 0 is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'd7);
    checkOutput("t5_clear_state", 32'(state), 32'd0);
    checkOutput("t5_clear_count", 32'(count), 32'd0);
    checkOutput("t5_clear_done", 32'(done), 32'd0);
    step(1);
    checkOutput("t5_no_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    checkOutput("t5_start0_state", 32'(state), 32'd0);
    checkOutput("t5_start0_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    checkOutput("t5_load_max", 32'(count), 32'd65535);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    checkOutput("t5_clear_max", 32'(count), 32'd0);

    // Asynchronous reset mid-countdown
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    step(10);
    checkOutput("t6_count2", 32'(count), 32'd2);
    step(3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_state", 32'(state), 32'd0);
    checkOutput("t6_rst_count", 32'(count), 32'd0);
    checkOutput("t6_rst_tick", 32'(tick), 32'd0);
    checkOutput("t6_rst_expired", 32'(expired), 32'd0);
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    checkOutput("t6_start0_state", 32'(state), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    checkOutput("t6_load1", 32'(count), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    step(9);
    checkOutput("t6_tick", 32'(tick), 32'd1);
    checkOutput("t6_pre_done", 32'(done), 32'd0);
    step(1);
    checkOutput("t6_done", 32'(done), 32'd1);
    checkOutput("t6_count0", 32'(count), 32'd0);
    checkOutput("t6_state_done", 32'(state), 32'd3);
    checkOutput("t6_expired", 32'(expired), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
